// File: rtl/dac_sim_pkg.sv
// Shared types and helpers for the DAC behavioural model and its ADC counterpart.
package dac_sim_pkg;

    typedef enum logic {
        IDLE,
        RUN
    } dac_state_t;

    localparam string TYPE_SIGNED = "signed";
    localparam string TYPE_OFFSET = "offset";

    // Map a BITS-wide code to volts; full scale spans [-vpp/2, vpp/2).
    function automatic real code_to_real(
        input logic [31:0] code,
        input int unsigned bits,
        input real         vpp,
        input string       typ
    );
        longint v;
        longint span;
        span = longint'(1) << bits;
        v    = longint'(code) & (span - 1);
        if (typ == TYPE_OFFSET) begin
            v = v - (span >>> 1);
        end else if (v >= (span >>> 1)) begin
            v = v - span;
        end
        return real'(v) * vpp / real'(span);
    endfunction

endpackage

// File: rtl/dac_sim_fifo.sv
// Synchronous FIFO with occupancy count; registered pointers give
// write-then-read ordering, so an entry is never popped in its push cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full    = (r_level == LW'(DEPTH));
    assign o_empty   = (r_level == '0);
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign o_level   = r_level;

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage write; contents need no reset since level gates every read.
    always_ff @(posedge i_clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= i_wdata;
    end

endmodule

// File: rtl/dac_sim.sv
// Behavioural DAC: stream-fed FIFO, one sample per RATE_DIV clocks, PIPE-deep
// latency, real-valued output. Define DAC_SIM_RTZ_EN for return-to-zero output.
module dac_sim
    import dac_sim_pkg::*;
#(
    parameter int    BITS     = 8,
    parameter real   VPP      = 1.0,
    parameter int    PIPE     = 5,
    parameter string TYPE     = TYPE_SIGNED,
    parameter int    DEPTH    = 8,
    parameter int    RATE_DIV = 4,
    parameter int    PREFILL  = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [BITS-1:0]        s_code,
    input  logic                   s_valid,
    output logic                   s_ready,
    output real                    out,
    output logic                   strobe,
    output logic                   underrun,
    output logic [$clog2(DEPTH):0] level
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam int CW = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
    localparam bit IS_OFFSET = (TYPE == TYPE_OFFSET);
    localparam logic [BITS-1:0] ZERO_CODE =
        IS_OFFSET ? {1'b1, {(BITS-1){1'b0}}} : {BITS{1'b0}};

    dac_state_t      r_state;
    dac_state_t      w_state_next;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_next;
    logic            w_strobe;
    logic            w_underrun;
    logic            w_pop;
    logic            w_push;
    logic [BITS-1:0] w_rdata;
    logic [LW-1:0]   w_level;
    logic            w_full;
    logic            w_empty;
    logic [BITS-1:0] r_hold;
    logic [BITS-1:0] w_hold_next;
    logic [BITS-1:0] r_pipe [PIPE];
    real             w_out;

    // Reset gating keeps s_ready low while rst_n is asserted and lets it rise
    // in the first cycle after, when the registered level is already 0.
    assign s_ready = rst_n && !w_full;
    assign w_push  = s_valid && s_ready;

    sync_fifo #(
        .WIDTH (BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_push  (w_push),
        .i_wdata (s_code),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_level (w_level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // State and rate counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state, conversion strobe, pop and underrun decode.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = '0;
        w_strobe     = 1'b0;
        w_underrun   = 1'b0;
        w_pop        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_level >= LW'(PREFILL)) w_state_next = RUN;
            end
            RUN: begin
                if (r_cnt == CW'(RATE_DIV - 1)) begin
                    w_strobe = 1'b1;
                    if (w_empty) w_underrun = 1'b1;
                    else         w_pop      = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign strobe   = w_strobe;
    assign underrun = w_underrun;
    assign level    = w_level;

    // Stage 0 takes the hold register's next value, so a popped code reaches
    // the last stage exactly PIPE clocks after its strobe cycle.
    assign w_hold_next = w_pop ? w_rdata : r_hold;

    // Hold register and latency pipeline.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hold <= ZERO_CODE;
            for (int unsigned i = 0; i < PIPE; i++) r_pipe[i] <= ZERO_CODE;
        end else begin
            r_hold    <= w_hold_next;
            r_pipe[0] <= w_hold_next;
            for (int unsigned i = 1; i < PIPE; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

`ifdef DAC_SIM_RTZ_EN
    logic [CW-1:0] r_phase [PIPE];

    // Counter phase delayed alongside the data; fed with the next count so
    // phase 0 lines up with the first output clock of each sample.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < PIPE; i++) r_phase[i] <= '0;
        end else begin
            r_phase[0] <= w_cnt_next;
            for (int unsigned i = 1; i < PIPE; i++) r_phase[i] <= r_phase[i-1];
        end
    end

    // Return-to-zero output: second half of each period forced to 0.0.
    always_comb begin
        w_out = code_to_real(32'(r_pipe[PIPE-1]), BITS, VPP, TYPE);
        if (r_state != RUN) begin
            w_out = 0.0;
        end else if ((RATE_DIV > 1) && (int'(r_phase[PIPE-1]) >= RATE_DIV / 2)) begin
            w_out = 0.0;
        end
    end
`else
    // Zero-order-hold output of the last pipeline stage.
    always_comb begin
        w_out = code_to_real(32'(r_pipe[PIPE-1]), BITS, VPP, TYPE);
    end
`endif

    assign out = w_out;

endmodule
